// File: rtl/prism_cnt_pkg.sv
// Shared constants for the PRISM counter bank: register map, IRQ bit layout, channel limit.
// Optional capture registers are enabled by defining PRISM_CNT_CAPTURE_EN.
package prism_cnt_pkg;

    localparam int MAX_CNT = 4;

    localparam logic [5:0] ADDR_IRQ_STATUS   = 6'h00;
    localparam logic [5:0] ADDR_IRQ_ENABLE   = 6'h04;
    localparam logic [5:0] ADDR_PRELOAD_BASE = 6'h08;
    localparam logic [5:0] ADDR_COUNT_BASE   = 6'h18;
    localparam logic [5:0] ADDR_CTRL         = 6'h28;
    localparam logic [5:0] ADDR_CAPTURE_BASE = 6'h2C;

    localparam int IRQ_HALT     = 0;
    localparam int IRQ_CNT_BASE = 1;

    // Per-channel registers sit on consecutive 32-bit words from a bank base.
    function automatic logic [5:0] chan_addr(input logic [5:0] base, input int ch);
        return base + 6'(4 * ch);
    endfunction

endpackage

// File: rtl/prism_down_counter.sv
// One preloadable down-counter channel with halt, auto-reload and an expiry pulse.
module prism_down_counter
    import prism_cnt_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             halt,
    input  logic             dec,
    input  logic             load,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] preload,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count;
        expire  = 1'b0;
        if (wr_en) begin
            count_d = wr_data;
        end else if (halt) begin
            count_d = count;
        end else if (dec && (count != '0)) begin
            if (count == ONE) begin
                expire  = 1'b1;
                count_d = auto_reload ? preload : '0;
            end else begin
                count_d = count - ONE;
            end
        end else if (load && enable) begin
            count_d = preload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prism_counter_bank.sv
// Bank of NUM_CNT down-counters with maskable interrupts on the TinyQV peripheral bus.
// Define PRISM_CNT_CAPTURE_EN to add the cnt_capture input and CAPTURE_i registers at 0x2C+4i.
module prism_counter_bank
    import prism_cnt_pkg::*;
#(
    parameter int NUM_CNT = 2,
    parameter int CNT_W   = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         address,
    input  logic [31:0]        data_in,
    input  logic [1:0]         data_write_n,
    input  logic [1:0]         data_read_n,
    output logic [31:0]        data_out,
    output logic               data_ready,
    input  logic               fsm_enable,
    input  logic               fsm_halt,
    input  logic [NUM_CNT-1:0] cnt_dec,
    input  logic [NUM_CNT-1:0] cnt_load,
    output logic [NUM_CNT-1:0] cnt_zero,
    output logic               user_interrupt
`ifdef PRISM_CNT_CAPTURE_EN
    ,
    input  logic [NUM_CNT-1:0] cnt_capture
`endif
);

    localparam int IRQ_W = NUM_CNT + 1;

    logic             wr32;
    logic             halt_r;
    logic             halt_rise;
    logic [IRQ_W-1:0] irq_status;
    logic [IRQ_W-1:0] irq_enable;
    logic [IRQ_W-1:0] irq_set;
    logic [IRQ_W-1:0] irq_clr;
    logic [NUM_CNT-1:0] ctrl;
    logic [NUM_CNT-1:0] expire;
    logic [NUM_CNT-1:0] count_wr;
    logic [CNT_W-1:0]   preload_q [NUM_CNT];
    logic [CNT_W-1:0]   count_q   [NUM_CNT];

    assign data_ready = 1'b1;
    assign wr32       = (data_write_n == 2'b10);
    assign halt_rise  = fsm_halt & ~halt_r;
    assign irq_set    = {expire, halt_rise};
    assign irq_clr    = (wr32 && address == ADDR_IRQ_STATUS) ? data_in[IRQ_W-1:0] : '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, data_read_n, data_in};

    // Set is OR-ed after the W1C mask so a same-cycle event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_r     <= 1'b0;
            irq_status <= '0;
            irq_enable <= '0;
            ctrl       <= '0;
        end else begin
            halt_r     <= fsm_halt;
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            if (wr32 && address == ADDR_IRQ_ENABLE) irq_enable <= data_in[IRQ_W-1:0];
            if (wr32 && address == ADDR_CTRL)       ctrl       <= data_in[NUM_CNT-1:0];
        end
    end

    // NOTE: the preload array is a small register file, not RAM, so it takes the async reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) preload_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (wr32 && address == chan_addr(ADDR_PRELOAD_BASE, i)) begin
                    preload_q[i] <= data_in[CNT_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
        assign count_wr[g] = wr32 && (address == chan_addr(ADDR_COUNT_BASE, g));

        prism_down_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (count_wr[g]),
            .wr_data    (data_in[CNT_W-1:0]),
            .halt       (fsm_halt),
            .dec        (cnt_dec[g]),
            .load       (cnt_load[g]),
            .enable     (fsm_enable),
            .auto_reload(ctrl[g]),
            .preload    (preload_q[g]),
            .count      (count_q[g]),
            .zero       (cnt_zero[g]),
            .expire     (expire[g])
        );
    end

`ifdef PRISM_CNT_CAPTURE_EN
    logic [NUM_CNT-1:0] capture_r;
    logic [CNT_W-1:0]   capture_q [NUM_CNT];

    // Latches the register value before this edge's update, regardless of halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_r <= '0;
            for (int i = 0; i < NUM_CNT; i++) capture_q[i] <= '0;
        end else begin
            capture_r <= cnt_capture;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cnt_capture[i] && !capture_r[i]) capture_q[i] <= count_q[i];
            end
        end
    end
`endif

    always_comb begin
        data_out = '0;
        if (address == ADDR_IRQ_STATUS) data_out = 32'(irq_status);
        if (address == ADDR_IRQ_ENABLE) data_out = 32'(irq_enable);
        if (address == ADDR_CTRL)       data_out = 32'(ctrl);
        for (int i = 0; i < NUM_CNT; i++) begin
            if (address == chan_addr(ADDR_PRELOAD_BASE, i)) data_out = 32'(preload_q[i]);
            if (address == chan_addr(ADDR_COUNT_BASE, i))   data_out = 32'(count_q[i]);
`ifdef PRISM_CNT_CAPTURE_EN
            if (address == chan_addr(ADDR_CAPTURE_BASE, i)) data_out = 32'(capture_q[i]);
`endif
        end
    end

    assign user_interrupt = |(irq_status & irq_enable);

endmodule

// File: doc/prism_counter_bank.md
Name: prism_counter_bank

Overview:
- Parametrised bank of NUM_CNT preloadable down-counters with a small interrupt controller, on the TinyQV peripheral bus.
- Sits beside the PRISM FSM controller. PRISM output bits drive per-channel decrement and load strobes. Per-channel zero flags return to PRISM inputs.
- Generalises the single fixed 28-bit counter to N channels with configurable width, auto-reload mode, direct count write, and maskable multi-source interrupts (PRISM halt edge plus counter expiry).

Parameters:
- NUM_CNT, 2, number of counter channels, legal 1..4
- CNT_W, 28, counter and preload width in bits, legal 1..32

Ports:
- clk  in  1  peripheral clock (64 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- address  in  6  byte address within the block
- data_in  in  32  write data
- data_write_n  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit
- data_read_n  in  2  read request (unused; reads have no side effects)
- data_out  out  32  read data, combinational from address
- data_ready  out  1  tied 1
- fsm_enable  in  1  PRISM enable; gates strobe loads
- fsm_halt  in  1  PRISM halt; freezes all counters while 1
- cnt_dec  in  NUM_CNT  per-channel decrement strobe
- cnt_load  in  NUM_CNT  per-channel load-from-preload strobe
- cnt_zero  out  NUM_CNT  per-channel count==0, combinational from the count register
- user_interrupt  out  1  level interrupt, |(irq_status & irq_enable)

Behaviour:
- Only 32-bit writes (data_write_n == 2'b10) take effect. Other write widths are ignored.
- Register map:
  - 0x00 IRQ_STATUS: bit0 = halt rising edge, bit1+i = channel i expiry. W1C.
  - 0x04 IRQ_ENABLE: bits [NUM_CNT:0], R/W.
  - 0x08+4i PRELOAD_i: R/W, CNT_W bits.
  - 0x18+4i COUNT_i: read returns current count; write loads the count directly.
  - 0x28 CTRL: bit i = auto-reload enable for channel i.
- Unmapped addresses and channels at or above NUM_CNT read 0 and ignore writes. Read data above CNT_W is zero-extended.
- Reset: all counts, preloads, CTRL, IRQ_STATUS, IRQ_ENABLE and halt_r = 0. cnt_zero = all 1. user_interrupt = 0.
- Per-channel next count, in priority order:
  1. Bus write to COUNT_i: data_in[CNT_W-1:0], applies even while halted.
  2. Else if fsm_halt: hold.
  3. Else if cnt_dec[i] && count != 0:
     - if count == 1 && CTRL[i], load preload;
     - otherwise count - 1.
  4. Else if cnt_load[i] && fsm_enable: load preload.
  5. Else hold.
- Decrement at 0 never wraps; the count stays 0.
- Expiry event: a priority-3 decrement from count == 1. Sets IRQ_STATUS[1+i] one cycle later. A direct write to 0 does not set it.
- With auto-reload and preload == 0, expiry reloads 0; the channel then stays idle.
- Halt edge: halt_r registers fsm_halt. fsm_halt && !halt_r sets IRQ_STATUS[0].
- A set and a W1C clear of the same bit in the same cycle: set wins.
- Latency: strobe to count update is 1 cycle. Count to cnt_zero is combinational. Event to user_interrupt is 1 cycle.
- A PRELOAD write in the same cycle as a load uses the old preload value.
- Reset asserted mid-count clears immediately, asynchronously.

Optional Feature:
- Macro PRISM_CNT_CAPTURE_EN.
- Defined:
  - adds input cnt_capture (NUM_CNT bits) and CAPTURE_i registers at 0x2C+4i, read-only (only channels 0..3 fit in the 6-bit space);
  - a rising edge on cnt_capture[i] latches the pre-update count of channel i;
  - capture works while halted; reset value 0.
- Undefined: no port, no registers, and 0x2C+ reads 0.

Decomposition:
- Package prism_cnt_pkg:
  - address constants (ADDR_IRQ_STATUS, ADDR_IRQ_ENABLE, ADDR_PRELOAD_BASE, ADDR_COUNT_BASE, ADDR_CTRL, ADDR_CAPTURE_BASE);
  - IRQ bit index constants (IRQ_HALT = 0, IRQ_CNT_BASE = 1);
  - MAX_CNT = 4.
- Sub-module prism_down_counter, one channel, instantiated NUM_CNT times in a generate loop.
  - Inputs: write strobe and data, halt, dec, load, enable, auto-reload, preload.
  - Outputs: count, zero, expire pulse.
- The top level holds the bus decode, IRQ_STATUS/IRQ_ENABLE, the halt edge detector and the read mux.

Test Plan:
- Reset -> all reads 0, cnt_zero = 2'b11, user_interrupt = 0.
- PRELOAD_0 = 3, fsm_enable = 1, pulse cnt_load[0], hold cnt_dec[0] high 4 cycles -> COUNT_0 reads 3,2,1,0,0. IRQ_STATUS = 0x2 one cycle after the 1->0 step. With IRQ_ENABLE = 0x2, user_interrupt = 1. Write 0x2 to 0x00 -> interrupt drops next cycle.
- CTRL = 0x2, PRELOAD_1 = 2, load, then continuous dec -> COUNT_1 sequence 2,1,2,1, expiry bit 2 set at each 1->2 reload, cnt_zero[1] never 1.
- fsm_halt = 1 during dec -> count frozen. IRQ_STATUS[0] set on the halt rising edge. A write to COUNT_0 = 0x55 while halted reads back 0x55.
- Same cycle: expiry of channel 0 plus W1C of bit1 -> bit1 remains 1. 16-bit write to PRELOAD_0 -> ignored. Read 0x3C -> 0.
- PRISM_CNT_CAPTURE_EN: COUNT_0 = 10, dec running, cnt_capture[0] edge -> CAPTURE_0 reads the count value present in the edge cycle.
